// File: rtl/rvpipe_pkg.sv
// Shared rvpipe definitions for the M-extension sequencer: FSM state
// encoding, RV32M funct3 codes and operand-signedness helpers.
package rvpipe_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // rs1 is treated as two's complement (MULHSU included)
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as two's complement
    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Upper half of the funct3 space is divide/remainder
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned multiply/divide core: converts the
// incoming operands to magnitudes plus sign flags, and applies the final
// sign correction and result-half selection to the raw accumulator.
module muldiv_signfix
    import rvpipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]        i_f3,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [XLEN-1:0]   o_mag_a,
    output logic [XLEN-1:0]   o_mag_b,
    output logic              o_sa,
    output logic              o_sb,
    input  logic [2:0]        i_rf3,
    input  logic              i_rsa,
    input  logic              i_rsb,
    input  logic [2*XLEN-1:0] i_acc,
    output logic [XLEN-1:0]   o_result
);

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // Operand magnitudes: only negative values of signed operands are flipped
    always_comb begin
        o_sa    = f3_a_signed(i_f3) & i_a[XLEN-1];
        o_sb    = f3_b_signed(i_f3) & i_b[XLEN-1];
        o_mag_a = o_sa ? -i_a : i_a;
        o_mag_b = o_sb ? -i_b : i_b;
    end

    // Product sign = sA^sB, quotient sign = sA^sB, remainder sign = sA
    always_comb begin
        w_prod   = (i_rsa ^ i_rsb) ? -i_acc : i_acc;
        w_quo    = (i_rsa ^ i_rsb) ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
        w_rem    = i_rsa ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
        o_result = '0;
        case (i_rf3)
            F3_MUL:                  o_result = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                o_result = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:         o_result = w_quo;
            default:                 o_result = w_rem;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the E stage.
// IDLE latches the op, BUSY runs XLEN shift-add or restoring-divide steps,
// DONE presents the sign-corrected result for one cycle. Divide by zero and
// signed overflow skip iteration. Defining MDU_FAST_MUL_EN replaces the
// iterative multiply with a single-cycle combinational multiplier.
module muldiv_ctrl
    import rvpipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MulDivE,
    input  logic [2:0]      Funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            StallMDE,
    output logic [XLEN-1:0] MDResultE,
    output logic            MDDoneE
);

    md_state_t         r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [2*XLEN-1:0] r_acc;      // product, or {remainder, quotient/dividend}
    logic [XLEN-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic [2:0]        r_f3;
    logic              r_sa;
    logic              r_sb;
    logic              r_special;
    logic [XLEN-1:0]   r_sres;

    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_post;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_div_next;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .i_f3     (Funct3E),
        .i_a      (SrcAE),
        .i_b      (SrcBE),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_sa     (w_sa),
        .o_sb     (w_sb),
        .i_rf3    (r_f3),
        .i_rsa    (r_sa),
        .i_rsb    (r_sb),
        .i_acc    (r_acc),
        .o_result (w_post)
    );

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;

    // Single-cycle unsigned product of the operand magnitudes
    always_comb w_fast_prod = (2*XLEN)'(w_mag_a) * (2*XLEN)'(w_mag_b);
`endif

    // Special divide detection and one iteration step of each algorithm
    always_comb begin
        w_div_zero  = (SrcBE == '0);
        w_div_ovf   = f3_a_signed(Funct3E) && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (SrcBE == '1);
        // Multiplier bits sit in acc[XLEN-1:0] and are consumed from bit 0
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
        // Dividend bits shift out of the low half into the remainder
        w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_ge    = (w_div_shift >= {1'b0, r_opb});
        w_div_next  = w_div_ge ? {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                               : {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end

    // Controller FSM and iteration datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_f3      <= F3_MUL;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_special <= 1'b0;
            r_sres    <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (MulDivE) begin
                        r_f3      <= Funct3E;
                        r_sa      <= w_sa;
                        r_sb      <= w_sb;
                        r_cnt     <= '0;
                        r_special <= 1'b0;
                        if (f3_is_div(Funct3E)) begin
                            r_opb <= w_mag_b;
                            r_acc <= {{XLEN{1'b0}}, w_mag_a};
                            if (w_div_zero) begin
                                r_special <= 1'b1;
                                r_sres    <= Funct3E[1] ? SrcAE : '1;
                                r_state   <= MD_DONE;
                            end else if (w_div_ovf) begin
                                r_special <= 1'b1;
                                r_sres    <= Funct3E[1] ? '0 : SrcAE;
                                r_state   <= MD_DONE;
                            end else begin
                                r_state   <= MD_BUSY;
                            end
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            r_opb   <= w_mag_a;
                            r_acc   <= w_fast_prod;
                            r_state <= MD_DONE;
`else
                            r_opb   <= w_mag_a;
                            r_acc   <= {{XLEN{1'b0}}, w_mag_b};
                            r_state <= MD_BUSY;
`endif
                        end
                    end
                end
                MD_BUSY: begin
                    r_acc <= f3_is_div(r_f3) ? w_div_next : w_mul_next;
                    if (r_cnt == CNTW'(XLEN-1)) begin
                        r_state <= MD_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    // Stall is combinational on MulDivE in IDLE so E holds in the issue cycle
    always_comb begin
        StallMDE  = !reset && (((r_state == MD_IDLE) && MulDivE) || (r_state == MD_BUSY));
        MDDoneE   = (r_state == MD_DONE);
        MDResultE = '0;
        if (r_state == MD_DONE) begin
            MDResultE = r_special ? r_sres : w_post;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, hand sequences for
// back-to-back ops and reset abort, and random ops against an arithmetic model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MulDivE;
    logic [2:0]  Funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        StallMDE;
    logic [31:0] MDResultE;
    logic        MDDoneE;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif
    localparam int DIV_STALL = 33;

    muldiv_ctrl #(.XLEN(32), .CNTW(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .MulDivE   (MulDivE),
        .Funct3E   (Funct3E),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .StallMDE  (StallMDE),
        .MDResultE (MDResultE),
        .MDDoneE   (MDDoneE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          stall;
        string       nm;
    } vec_t;

    vec_t tbl[14];

    // RV32M result computed with wide integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Stalled cycles before the result appears
    function automatic int ref_stall(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f3[2]) return MUL_STALL;
        if (b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_STALL;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op at a negedge, count stalled cycles until done, check result
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_stall,
                          input bit hold, input bit scramble, input string nm);
        int cyc;
        int stalls;
        bit done;
        MulDivE = 1'b1;
        Funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        cyc     = 0;
        stalls  = 0;
        done    = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (MDDoneE) begin
                done = 1'b1;
            end else begin
                if (StallMDE) stalls++;
                cyc++;
                @(negedge clk);
                if (scramble) begin
                    SrcAE = $urandom;
                    SrcBE = $urandom;
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no MDDoneE within 200 cycles", nm);
        end else begin
            check({nm, " result"}, MDResultE, exp_res);
            check({nm, " stalls"}, 32'(stalls), 32'(exp_stall));
            check({nm, " cycles"}, 32'(cyc), 32'(exp_stall));
            check({nm, " stall in done"}, {31'h0, StallMDE}, 32'h0);
        end
        @(negedge clk);
        if (!hold) begin
            MulDivE = 1'b0;
            #1;
            check({nm, " done pulse"}, {31'h0, MDDoneE}, 32'h0);
            check({nm, " idle stall"}, {31'h0, StallMDE}, 32'h0);
        end
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          sel;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_STALL, "MUL 7x-3"};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_STALL, "MULH min*min"};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL, "MULHU max*max"};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_STALL, "MULHSU -1x2"};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_STALL, "DIV -7/2"};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_STALL, "REM -7/2"};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        DIV_STALL, "DIVU 100/7"};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         DIV_STALL, "REMU 100/7"};
        tbl[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,         "DIV 5/0"};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1,         "REM 5/0"};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,         "DIV ovf"};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1,         "REM ovf"};
        tbl[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1,         "DIVU 9/0"};
        tbl[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1,         "REMU 9/0"};

        reset   = 1'b1;
        MulDivE = 1'b1;
        Funct3E = 3'd0;
        SrcAE   = 32'd0;
        SrcBE   = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("reset StallMDE", {31'h0, StallMDE}, 32'h0);
        check("reset MDDoneE", {31'h0, MDDoneE}, 32'h0);
        check("reset MDResultE", MDResultE, 32'h0);
        reset   = 1'b0;
        MulDivE = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].stall, 1'b0, 1'b0, tbl[i].nm);
        end

        // Back-to-back DIVU with MulDivE held through DONE and operands toggling in BUSY
        run_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_STALL, 1'b1, 1'b1, "b2b DIVU #1");
        run_op(3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, DIV_STALL, 1'b0, 1'b1, "b2b DIVU #2");

        // Reset aborts a divide at BUSY count 10
        MulDivE = 1'b1;
        Funct3E = 3'd5;
        SrcAE   = 32'd1000;
        SrcBE   = 32'd3;
        repeat (11) @(negedge clk);
        #1;
        check("abort busy before reset", {31'h0, StallMDE}, 32'h1);
        reset = 1'b1;
        #1;
        check("abort StallMDE", {31'h0, StallMDE}, 32'h0);
        check("abort MDDoneE", {31'h0, MDDoneE}, 32'h0);
        check("abort MDResultE", MDResultE, 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        MulDivE = 1'b0;
        #1;
        check("post-abort StallMDE", {31'h0, StallMDE}, 32'h0);
        check("post-abort MDDoneE", {31'h0, MDDoneE}, 32'h0);
        @(negedge clk);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, MUL_STALL, 1'b0, 1'b0, "MUL 3x4 after abort");

        // Random ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rf3, ra, rb, ref_result(rf3, ra, rb), ref_stall(rf3, ra, rb),
                   1'b0, 1'($urandom_range(0, 1)), $sformatf("rand%0d f3=%0d", i, rf3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
